// File: rtl/axi_node_pkg.sv
// axi_node_pkg: shared routing-ID types and default port geometry for the AXI node.
package axi_node_pkg;
  localparam int NODE_N_TARG = 7;
  localparam int NODE_LOG_N_TARG = $clog2(NODE_N_TARG);
  localparam int NODE_ID_W = NODE_LOG_N_TARG + NODE_N_TARG;
  typedef struct packed {
    logic [NODE_LOG_N_TARG-1:0] bin;
    logic [NODE_N_TARG-1:0] oh;
  } id_t;
endpackage

// File: rtl/axi_dw_id_fifo.sv
// axi_dw_id_fifo: in-order routing-ID FIFO; AXI_DW_BYPASS_EN lets a push into an empty FIFO be head at once.
module axi_dw_id_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] data_out
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  logic stored, wr, rd;
  assign stored = count != '0;
  assign full = count == (PW+1)'(DEPTH);
  assign rd = pop & stored;
`ifdef AXI_DW_BYPASS_EN
  // An empty FIFO forwards the incoming ID; a same-cycle pop consumes it without storing.
  assign empty = ~stored & ~push;
  assign data_out = stored ? mem[rptr] : data_in;
  assign wr = push & ~full & ~(~stored & pop);
`else
  assign empty = ~stored;
  assign data_out = mem[rptr];
  assign wr = push & ~full;
`endif
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + {{PW{1'b0}}, wr} - {{PW{1'b0}}, rd};
    end
endmodule

// File: rtl/axi_dw_allocator.sv
// axi_dw_allocator: routes W beats from the target port at the ID-FIFO head, popping on WLAST.
// Build option AXI_DW_BYPASS_EN gives zero-latency head on push into an empty FIFO.
module axi_dw_allocator
  import axi_node_pkg::*;
#(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_NUMBYTES = AXI_DATA_W / 8,
  parameter int AXI_USER_W = 6,
  parameter int N_TARG_PORT = NODE_N_TARG,
  parameter int LOG_N_TARG = $clog2(N_TARG_PORT),
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_TARG_PORT*AXI_DATA_W-1:0]   wdata_i,
  input  logic [N_TARG_PORT*AXI_NUMBYTES-1:0] wstrb_i,
  input  logic [N_TARG_PORT-1:0]              wlast_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]   wuser_i,
  input  logic [N_TARG_PORT-1:0]              wvalid_i,
  output logic [N_TARG_PORT-1:0]              wready_o,
  output logic [AXI_DATA_W-1:0]               wdata_o,
  output logic [AXI_NUMBYTES-1:0]             wstrb_o,
  output logic                                wlast_o,
  output logic [AXI_USER_W-1:0]               wuser_o,
  output logic                                wvalid_o,
  input  logic                                wready_i,
  input  logic                                push_ID_i,
  input  logic [LOG_N_TARG+N_TARG_PORT-1:0]   ID_i,
  output logic                                grant_FIFO_ID_o
);
  localparam int ID_W = LOG_N_TARG + N_TARG_PORT;
  logic [ID_W-1:0] head;
  logic [LOG_N_TARG-1:0] sel_bin;
  logic [N_TARG_PORT-1:0] sel_oh;
  logic full, empty, pop;
  assign sel_bin = head[ID_W-1:N_TARG_PORT];
  assign sel_oh = head[N_TARG_PORT-1:0];
  assign grant_FIFO_ID_o = ~full;
  assign pop = wvalid_o & wready_i & wlast_o;
  assign wdata_o = empty ? '0 : wdata_i[sel_bin*AXI_DATA_W +: AXI_DATA_W];
  assign wstrb_o = empty ? '0 : wstrb_i[sel_bin*AXI_NUMBYTES +: AXI_NUMBYTES];
  assign wuser_o = empty ? '0 : wuser_i[sel_bin*AXI_USER_W +: AXI_USER_W];
  assign wlast_o = ~empty & wlast_i[sel_bin];
  assign wvalid_o = ~empty & wvalid_i[sel_bin];
  assign wready_o = {N_TARG_PORT{~empty & wready_i}} & sel_oh;
  axi_dw_id_fifo #(.DATA_W(ID_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push_ID_i),
    .pop(pop),
    .data_in(ID_i),
    .full(full),
    .empty(empty),
    .data_out(head)
  );
endmodule

// File: tb/tb_axi_dw_allocator.sv
// tb_axi_dw_allocator: directed scenarios for the W-channel allocator with hand-computed expectations.
module tb_axi_dw_allocator;
  import axi_node_pkg::*;
  logic clk = 0;
  logic rst_n;
  logic [7*64-1:0] wdata_i;
  logic [7*8-1:0] wstrb_i;
  logic [6:0] wlast_i, wvalid_i, wready_o;
  logic [7*6-1:0] wuser_i;
  logic [63:0] wdata_o;
  logic [7:0] wstrb_o;
  logic wlast_o, wvalid_o, wready_i, push_ID_i, grant_FIFO_ID_o;
  logic [5:0] wuser_o;
  logic [9:0] ID_i;
  int tests = 0;
  int fails = 0;

  axi_dw_allocator dut (
    .clk(clk), .rst_n(rst_n),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wuser_i(wuser_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wuser_o(wuser_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .push_ID_i(push_ID_i), .ID_i(ID_i), .grant_FIFO_ID_o(grant_FIFO_ID_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(int p, int b);
    return {32'hD00DF00D, 16'(p), 16'(b)};
  endfunction

  function automatic logic [9:0] mk(int p);
    id_t v;
    v.bin = 3'(p);
    v.oh = 7'(1 << p);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic clr;
    wdata_i = '0; wstrb_i = '0; wlast_i = '0; wuser_i = '0; wvalid_i = '0;
    push_ID_i = 0; ID_i = '0;
  endtask

  task automatic drive_port(input int p, input logic v, input logic l, input int b);
    wvalid_i[p] = v;
    wlast_i[p] = l;
    wdata_i[p*64 +: 64] = pat(p, b);
    wstrb_i[p*8 +: 8] = 8'(8'hF0 | p);
    wuser_i[p*6 +: 6] = 6'(p + 32);
  endtask

  task automatic test_reset;
    rst_n = 0; wready_i = 1; clr;
    #2;
    tests++; if (grant_FIFO_ID_o !== 1'b1) begin fails++; $display("FAIL reset_grant got %b want 1", grant_FIFO_ID_o); end
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL reset_wvalid got %b want 0", wvalid_o); end
    tests++; if (wready_o !== 7'b0) begin fails++; $display("FAIL reset_wready got %b want 0", wready_o); end
    tests++; if (wdata_o !== 64'b0) begin fails++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
    tick; tick;
    rst_n = 1;
  endtask

  task automatic test_single;
    tick; clr; wready_i = 1; push_ID_i = 1; ID_i = mk(2);
    sample;
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL single_push_wvalid got %b want 0", wvalid_o); end
    for (int b = 0; b < 4; b++) begin
      tick;
      push_ID_i = 0;
      drive_port(2, 1, b == 3, b);
      sample;
      tests++; if (wvalid_o !== 1'b1) begin fails++; $display("FAIL single_wvalid beat %0d got %b want 1", b, wvalid_o); end
      tests++; if (wready_o !== 7'b0000100) begin fails++; $display("FAIL single_wready beat %0d got %b want 0000100", b, wready_o); end
      tests++; if (wdata_o !== pat(2, b)) begin fails++; $display("FAIL single_wdata beat %0d got %h want %h", b, wdata_o, pat(2, b)); end
      tests++; if (wlast_o !== (b == 3)) begin fails++; $display("FAIL single_wlast beat %0d got %b", b, wlast_o); end
    end
    tests++; if (wstrb_o !== 8'hF2 || wuser_o !== 6'd34) begin fails++; $display("FAIL single_strb_user got %h/%0d want f2/34", wstrb_o, wuser_o); end
    tick; clr;
    sample;
    tests++; if (wvalid_o !== 1'b0 || wready_o !== 7'b0) begin fails++; $display("FAIL single_empty_after got %b/%b want 0/0", wvalid_o, wready_o); end
  endtask

  task automatic test_order;
    int exp_p [6] = '{5, 5, 0, 0, 3, 3};
    int idx [7] = '{0, 0, 0, 0, 0, 0, 0};
    int ports [3] = '{0, 3, 5};
    tick; clr; wready_i = 1; push_ID_i = 1; ID_i = mk(5);
    sample;
    for (int k = 0; k < 6; k++) begin
      tick;
      push_ID_i = (k < 2);
      ID_i = (k == 0) ? mk(0) : mk(3);
      for (int j = 0; j < 3; j++)
        drive_port(ports[j], idx[ports[j]] < 2, idx[ports[j]] == 1, idx[ports[j]]);
      sample;
      tests++; if (wvalid_o !== 1'b1) begin fails++; $display("FAIL order_wvalid cycle %0d got %b want 1", k, wvalid_o); end
      tests++; if (wready_o !== 7'(1 << exp_p[k])) begin fails++; $display("FAIL order_wready cycle %0d got %b want port %0d", k, wready_o, exp_p[k]); end
      tests++; if (wdata_o !== pat(exp_p[k], k % 2)) begin fails++; $display("FAIL order_wdata cycle %0d got %h want %h", k, wdata_o, pat(exp_p[k], k % 2)); end
      idx[exp_p[k]]++;
    end
    tick; clr;
    sample;
    tests++; if (wready_o !== 7'b0) begin fails++; $display("FAIL order_empty_after got %b want 0", wready_o); end
  endtask

  task automatic test_full;
    tick; clr; wready_i = 1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      push_ID_i = 1; ID_i = mk(1);
      sample;
      tests++; if (grant_FIFO_ID_o !== 1'b1) begin fails++; $display("FAIL full_grant_pre push %0d got %b want 1", k, grant_FIFO_ID_o); end
    end
    tick;
    push_ID_i = 1; ID_i = mk(4);
    drive_port(1, 1, 1, 0);
    drive_port(4, 1, 1, 0);
    sample;
    tests++; if (grant_FIFO_ID_o !== 1'b0) begin fails++; $display("FAIL full_grant_low got %b want 0", grant_FIFO_ID_o); end
    tests++; if (wvalid_o !== 1'b1) begin fails++; $display("FAIL full_wvalid got %b want 1", wvalid_o); end
    tick;
    push_ID_i = 1; ID_i = mk(4);
    sample;
    tests++; if (grant_FIFO_ID_o !== 1'b1) begin fails++; $display("FAIL full_grant_rise got %b want 1", grant_FIFO_ID_o); end
    for (int d = 0; d < 8; d++) begin
      if (d > 0) begin
        tick;
        push_ID_i = 0;
        sample;
      end
      tests++; if (wready_o !== ((d < 7) ? 7'b0000010 : 7'b0010000)) begin fails++; $display("FAIL full_drain_wready entry %0d got %b", d, wready_o); end
    end
    tests++; if (wdata_o !== pat(4, 0)) begin fails++; $display("FAIL full_ninth_wdata got %h want %h", wdata_o, pat(4, 0)); end
    tick;
    sample;
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL full_empty_after got %b want 0", wvalid_o); end
    clr;
  endtask

  task automatic test_backpressure;
    logic rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int beat [5] = '{0, 1, 1, 1, 2};
    tick; clr; wready_i = 1; push_ID_i = 1; ID_i = mk(6);
    sample;
    tick;
    ID_i = mk(0);
    drive_port(0, 1, 1, 0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        tick;
        push_ID_i = 0;
      end
      wready_i = rdy[c];
      drive_port(6, 1, beat[c] == 2, beat[c]);
      sample;
      tests++; if (wdata_o !== pat(6, beat[c])) begin fails++; $display("FAIL bp_wdata cycle %0d got %h want %h", c, wdata_o, pat(6, beat[c])); end
      tests++; if (wready_o !== (rdy[c] ? 7'b1000000 : 7'b0)) begin fails++; $display("FAIL bp_wready cycle %0d got %b", c, wready_o); end
    end
    tick;
    wready_i = 1;
    drive_port(6, 0, 0, 0);
    sample;
    tests++; if (wready_o !== 7'b0000001 || wdata_o !== pat(0, 0)) begin fails++; $display("FAIL bp_next_head got %b/%h want 0000001/%h", wready_o, wdata_o, pat(0, 0)); end
    tick;
    sample;
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL bp_empty_after got %b want 0", wvalid_o); end
    clr;
  endtask

  task automatic test_reset_mid;
    tick; clr; wready_i = 1; push_ID_i = 1; ID_i = mk(2);
    sample;
    tick; ID_i = mk(4); drive_port(2, 1, 0, 0);
    sample;
    tick; ID_i = mk(5); drive_port(2, 1, 0, 1);
    sample;
    tick; push_ID_i = 0; drive_port(2, 1, 0, 2);
    #1 rst_n = 0;
    #1;
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL rstmid_wvalid got %b want 0", wvalid_o); end
    tests++; if (grant_FIFO_ID_o !== 1'b1) begin fails++; $display("FAIL rstmid_grant got %b want 1", grant_FIFO_ID_o); end
    tests++; if (wready_o !== 7'b0) begin fails++; $display("FAIL rstmid_wready got %b want 0", wready_o); end
    tick;
    rst_n = 1;
    sample;
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL rstmid_empty got %b want 0", wvalid_o); end
    drive_port(2, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick;
      push_ID_i = 1; ID_i = mk(3);
      sample;
      tests++; if (grant_FIFO_ID_o !== 1'b1) begin fails++; $display("FAIL rstmid_count push %0d grant got %b want 1", k, grant_FIFO_ID_o); end
    end
    tick;
    push_ID_i = 0;
    sample;
    tests++; if (grant_FIFO_ID_o !== 1'b0) begin fails++; $display("FAIL rstmid_count_full grant got %b want 0", grant_FIFO_ID_o); end
    rst_n = 0;
    tick;
    rst_n = 1;
  endtask

  task automatic test_bypass;
    tick; clr; wready_i = 1; push_ID_i = 1; ID_i = mk(1);
    drive_port(1, 1, 1, 0);
    sample;
`ifdef AXI_DW_BYPASS_EN
    tests++; if (wvalid_o !== 1'b1 || wdata_o !== pat(1, 0)) begin fails++; $display("FAIL bypass_same_cycle got %b/%h want 1/%h", wvalid_o, wdata_o, pat(1, 0)); end
    tick;
    push_ID_i = 0;
    sample;
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL bypass_empty_after got %b want 0", wvalid_o); end
`else
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL bypass_push_cycle got %b want 0", wvalid_o); end
    tick;
    push_ID_i = 0;
    sample;
    tests++; if (wvalid_o !== 1'b1 || wlast_o !== 1'b1) begin fails++; $display("FAIL bypass_next_cycle got %b/%b want 1/1", wvalid_o, wlast_o); end
    tick;
    sample;
    tests++; if (wvalid_o !== 1'b0) begin fails++; $display("FAIL bypass_empty_after got %b want 0", wvalid_o); end
`endif
    clr;
  endtask

  initial begin
    test_reset;
    test_single;
    test_order;
    test_full;
    test_backpressure;
    test_reset_mid;
    test_bypass;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
